// File: rtl/mi_arb_pkg.sv
// Shared types and helpers for the round-robin MI arbiter.
package mi_arb_pkg;

   // Bus widths carried by the request struct; the arbiter parameters must match.
   localparam int MI_DATA_WIDTH = 32;
   localparam int MI_ADDR_WIDTH = 32;

   // One MI request as seen on the slave side of the arbiter.
   typedef struct packed {
      logic [MI_DATA_WIDTH-1:0]   dwr;
      logic [MI_ADDR_WIDTH-1:0]   addr;
      logic [MI_DATA_WIDTH/8-1:0] be;
      logic                       rd;
      logic                       wr;
   } mi_req_t;

   // Ceiling log2; log2(1) = 0.
   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Width of a master index; never narrower than one bit.
   function automatic int id_width(input int masters);
      return (masters <= 2) ? 1 : log2(masters);
   endfunction

endpackage

// File: rtl/mi_rr_arbiter_if.sv
// MI bus bundle. PORTS lanes are packed side by side (lane i at [i*W +: W]).
// The arbiter uses it as a slave towards the masters and as a master towards the slave.
interface mi_rr_arbiter_if #(
   parameter int PORTS      = 1,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [PORTS*DATA_WIDTH-1:0]   dwr;
   logic [PORTS*ADDR_WIDTH-1:0]   addr;
   logic [PORTS*DATA_WIDTH/8-1:0] be;
   logic [PORTS-1:0]              rd;
   logic [PORTS-1:0]              wr;
   logic [PORTS-1:0]              ardy;
   logic [PORTS*DATA_WIDTH-1:0]   drd;
   logic [PORTS-1:0]              drdy;

   // Requester side: issues requests, receives acceptance and read data.
   modport master (output dwr, addr, be, rd, wr, input ardy, drd, drdy);
   // Responder side: receives requests, returns acceptance and read data.
   modport slave  (input dwr, addr, be, rd, wr, output ardy, drd, drdy);
endinterface

// File: rtl/mi_arb_id_fifo.sv
// First-word-fall-through FIFO holding the master index of each in-flight read.
// DEPTH must be a power of two, at least 2. A push while full is dropped even if
// a pop happens in the same cycle.
module mi_arb_id_fifo
   import mi_arb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = log2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write.
   // NOTE: the array has no reset; entries are only read after being written, and leaving it out keeps it in plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mi_rr_arbiter.sv
// Round-robin arbiter sharing one MI slave between MASTERS requesters.
// Requests pass through combinationally; a stalled request locks the grant until
// accepted. Read issuers are queued in order so DRDY is routed back to its master.
module mi_rr_arbiter
   import mi_arb_pkg::*;
#(
   parameter int MASTERS        = 2,
   parameter int DATA_WIDTH     = MI_DATA_WIDTH,
   parameter int ADDR_WIDTH     = MI_ADDR_WIDTH,
   parameter int RD_OUTSTANDING = 16
) (
   input  logic              clk,
   input  logic              reset,
   mi_rr_arbiter_if.slave    rx,
   mi_rr_arbiter_if.master   tx,
   output logic              err_unexp_drdy
);
   localparam int ID_W = id_width(MASTERS);
   localparam int BE_W = DATA_WIDTH / 8;

   if (DATA_WIDTH != MI_DATA_WIDTH || ADDR_WIDTH != MI_ADDR_WIDTH) begin : g_width_check
      $error("mi_rr_arbiter: DATA_WIDTH/ADDR_WIDTH must match mi_arb_pkg widths");
   end

   logic [MASTERS-1:0] req, eligible;
   logic [ID_W-1:0]    rr_ptr, lock_idx, sel, scan_idx;
   logic               lock, sel_valid;
   logic               presented, accept;
   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ID_W-1:0]    fifo_head;
   mi_req_t            req_sel;

   assign req      = rx.rd | rx.wr;
   assign eligible = req & (rx.wr | {MASTERS{~fifo_full}});

   // Pick the locked master, else the first eligible one at or after rr_ptr.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sel       = lock_idx;
      sel_valid = lock;
      scan_idx  = '0;
      if (!lock) begin
         sel       = '0;
         sel_valid = 1'b0;
         // Descending scan: the nearest eligible master after rr_ptr is written last.
         for (int k = MASTERS - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % MASTERS);
            if (eligible[scan_idx]) begin
               sel       = scan_idx;
               sel_valid = 1'b1;
            end
         end
      end
   end

   // Route the selected master's request and acceptance.
   always_comb begin
      req_sel = '0;
      rx.ardy = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (sel_valid && sel == ID_W'(i)) begin
            req_sel.dwr  = rx.dwr[i*DATA_WIDTH +: DATA_WIDTH];
            req_sel.addr = rx.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            req_sel.be   = rx.be[i*BE_W +: BE_W];
            req_sel.rd   = rx.rd[i];
            req_sel.wr   = rx.wr[i];
            rx.ardy[i]   = tx.ardy[0];
         end
      end
   end

   assign tx.dwr  = req_sel.dwr;
   assign tx.addr = req_sel.addr;
   assign tx.be   = req_sel.be;
   assign tx.rd   = req_sel.rd;
   assign tx.wr   = req_sel.wr;

   assign presented = req_sel.rd | req_sel.wr;
   assign accept    = presented & tx.ardy[0];
   assign fifo_push = accept & req_sel.rd;
   assign fifo_pop  = tx.drdy[0] & ~fifo_empty;

   // Return read data to the master at the head of the ID FIFO.
   always_comb begin
      rx.drdy = '0;
      rx.drd  = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (fifo_pop && fifo_head == ID_W'(i)) begin
            rx.drdy[i]                         = 1'b1;
            rx.drd[i*DATA_WIDTH +: DATA_WIDTH] = tx.drd;
         end
      end
   end

   // Lock, round-robin pointer and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr         <= '0;
         lock           <= 1'b0;
         lock_idx       <= '0;
         err_unexp_drdy <= 1'b0;
      end else begin
         // Hold the grant while the presented request is stalled; release on acceptance.
         lock     <= presented & ~tx.ardy[0];
         lock_idx <= sel;
         if (accept) rr_ptr <= (sel == ID_W'(MASTERS - 1)) ? '0 : sel + ID_W'(1);
         if (tx.drdy[0] && fifo_empty) err_unexp_drdy <= 1'b1;
      end
   end

   mi_arb_id_fifo #(
      .DEPTH (RD_OUTSTANDING),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (sel),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A master must never request a read and a write at once.
   assert property (@(posedge clk) disable iff (reset) (rx.rd & rx.wr) == '0);

endmodule

// File: tb/tb_mi_rr_arbiter.sv
// Directed bench for mi_rr_arbiter with grant and read-response scoreboards.
module tb_mi_rr_arbiter;

   localparam int M  = 3;
   localparam int DW = 32;
   localparam int AW = 32;

   typedef struct {
      int unsigned master;
      logic [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic reset;
   logic err;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cnt [M];

   int unsigned grant_q[$];
   rsp_t        rsp_q[$];

   always #5 clk = ~clk;

   mi_rr_arbiter_if #(.PORTS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rx_bus ();
   mi_rr_arbiter_if #(.PORTS(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tx_bus ();

   mi_rr_arbiter #(
      .MASTERS        (M),
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .RD_OUTSTANDING (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rx             (rx_bus),
      .tx             (tx_bus),
      .err_unexp_drdy (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int m, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] dwr);
      rx_bus.rd[m]            = rd;
      rx_bus.wr[m]            = wr;
      rx_bus.addr[m*AW +: AW] = addr;
      rx_bus.dwr[m*DW +: DW]  = dwr;
      rx_bus.be[m*4 +: 4]     = 4'hf;
   endtask

   task automatic clear_reqs();
      rx_bus.rd   = '0;
      rx_bus.wr   = '0;
      rx_bus.addr = '0;
      rx_bus.dwr  = '0;
      rx_bus.be   = '0;
   endtask

   task automatic check_grant(input string tag);
      int unsigned m;
      if (grant_q.size() == 0) check(tag, 32'(rx_bus.ardy), 32'h0);
      else begin
         m = grant_q.pop_front();
         check(tag, 32'(rx_bus.ardy), 32'(1) << m);
      end
   endtask

   task automatic check_rsp(input string tag);
      rsp_t r;
      if (rsp_q.size() == 0) check({tag, "_none"}, 32'(rx_bus.drdy), 32'h0);
      else begin
         r = rsp_q.pop_front();
         check({tag, "_vld"}, 32'(rx_bus.drdy), 32'(1) << r.master);
         check({tag, "_data"}, rx_bus.drd[r.master*DW +: DW], r.data);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          mst   [3];
      logic [31:0] addr  [3];
      logic [31:0] dat   [3];
      int          rtime [3];
      rsp_t        r;

      reset = 1'b1;
      clear_reqs();
      tx_bus.ardy = 1'b0;
      tx_bus.drd  = '0;
      tx_bus.drdy = 1'b0;

      // Reset state: nothing selected, all outputs low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tx_rd", 32'(tx_bus.rd), 32'h0);
      check("rst_tx_wr", 32'(tx_bus.wr), 32'h0);
      check("rst_tx_addr", tx_bus.addr, 32'h0);
      check("rst_ardy", 32'(rx_bus.ardy), 32'h0);
      check("rst_drdy", 32'(rx_bus.drdy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      next_cycle();
      reset = 1'b0;

      // Fairness: three masters writing continuously, slave always ready.
      tx_bus.ardy = 1'b1;
      for (int i = 0; i < M; i++) set_req(i, 1'b0, 1'b1, 32'(256 * (i + 1)), 32'hA000 + 32'(i));
      for (int n = 0; n < 300; n++) grant_q.push_back(n % M);
      for (int i = 0; i < M; i++) cnt[i] = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (grant_q.size() > 0) check("rr_addr", tx_bus.addr, 32'(256 * (grant_q[0] + 1)));
         check_grant("rr_grant");
         for (int i = 0; i < M; i++) if (rx_bus.ardy[i]) cnt[i]++;
         next_cycle();
      end
      clear_reqs();
      for (int i = 0; i < M; i++) check("rr_count", 32'(cnt[i]), 32'd100);

      // Lock: master 1 read stalls 5 cycles; master 0 joins from cycle 2.
      tx_bus.ardy = 1'b0;
      set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check("lock_addr", tx_bus.addr, 32'h40);
         check("lock_txrd", 32'(tx_bus.rd), 32'h1);
         check("lock_ardy", 32'(rx_bus.ardy), 32'h0);
         next_cycle();
         if (c == 1) set_req(0, 1'b0, 1'b1, 32'h10, 32'h55);
      end
      tx_bus.ardy = 1'b1;
      grant_q.push_back(1);
      r.master = 1; r.data = 32'hD0D0_0001; rsp_q.push_back(r);
      @(negedge clk);
      check("lock_acc_addr", tx_bus.addr, 32'h40);
      check_grant("lock_acc_m1");
      next_cycle();
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      grant_q.push_back(0);
      @(negedge clk);
      check("lock_next_addr", tx_bus.addr, 32'h10);
      check_grant("lock_acc_m0");
      next_cycle();
      clear_reqs();
      tx_bus.drdy = 1'b1;
      tx_bus.drd  = 32'hD0D0_0001;
      @(negedge clk);
      check_rsp("lock_rsp");
      next_cycle();
      tx_bus.drdy = 1'b0;

      // Varying slave latency, responses come back in issue order.
      mst   = '{0, 1, 0};
      addr  = '{32'h200, 32'h300, 32'h400};
      dat   = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
      rtime = '{4, 10, 12};
      for (int k = 0; k < 14; k++) begin
         clear_reqs();
         tx_bus.drdy = 1'b0;
         if (k < 3) begin
            set_req(mst[k], 1'b1, 1'b0, addr[k], 32'h0);
            grant_q.push_back(mst[k]);
            r.master = mst[k]; r.data = dat[k]; rsp_q.push_back(r);
         end
         for (int j = 0; j < 3; j++) begin
            if (k == rtime[j]) begin
               tx_bus.drdy = 1'b1;
               tx_bus.drd  = dat[j];
            end
         end
         @(negedge clk);
         if (k < 3) begin
            check("ooo_addr", tx_bus.addr, addr[k]);
            check_grant("ooo_grant");
         end
         if (tx_bus.drdy) check_rsp("ooo_rsp");
         else check("ooo_idle", 32'(rx_bus.drdy), 32'h0);
         next_cycle();
      end
      clear_reqs();
      tx_bus.drdy = 1'b0;

      // FIFO full: four reads in flight, then a read and a write compete.
      for (int k = 0; k < 4; k++) begin
         set_req(2, 1'b1, 1'b0, 32'h500 + 32'(k), 32'h0);
         grant_q.push_back(2);
         r.master = 2; r.data = 32'hF000 + 32'(k); rsp_q.push_back(r);
         @(negedge clk);
         check_grant("full_fill");
         next_cycle();
      end
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
      set_req(1, 1'b0, 1'b1, 32'h700, 32'h77);
      grant_q.push_back(1);
      @(negedge clk);
      check("full_wr_addr", tx_bus.addr, 32'h700);
      check("full_wr_txwr", 32'(tx_bus.wr), 32'h1);
      check_grant("full_wr_grant");
      next_cycle();
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("full_blk_ardy", 32'(rx_bus.ardy), 32'h0);
         check("full_blk_txrd", 32'(tx_bus.rd), 32'h0);
         next_cycle();
      end
      tx_bus.drdy = 1'b1;
      tx_bus.drd  = 32'hF000;
      @(negedge clk);
      check_rsp("full_pop");
      check("full_pop_blk", 32'(rx_bus.ardy), 32'h0);
      next_cycle();
      tx_bus.drdy = 1'b0;
      grant_q.push_back(0);
      r.master = 0; r.data = 32'hF600; rsp_q.push_back(r);
      @(negedge clk);
      check("full_rd_addr", tx_bus.addr, 32'h600);
      check_grant("full_rd_grant");
      next_cycle();
      clear_reqs();
      for (int k = 0; k < 4; k++) begin
         tx_bus.drdy = 1'b1;
         tx_bus.drd  = (rsp_q.size() > 0) ? rsp_q[0].data : 32'h0;
         @(negedge clk);
         check_rsp("full_drain");
         next_cycle();
      end
      tx_bus.drdy = 1'b0;

      // Unexpected DRDY with nothing outstanding.
      tx_bus.drdy = 1'b1;
      tx_bus.drd  = 32'hBAD;
      @(negedge clk);
      check_rsp("unexp");
      check("unexp_err_pre", 32'(err), 32'h0);
      next_cycle();
      tx_bus.drdy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("unexp_err_sticky", 32'(err), 32'h1);
         next_cycle();
      end

      // Reset mid-operation: three reads outstanding and a lock on master 0.
      tx_bus.ardy = 1'b1;
      mst = '{2, 0, 1};
      for (int k = 0; k < 3; k++) begin
         clear_reqs();
         set_req(mst[k], 1'b1, 1'b0, 32'h800 + 32'(k), 32'h0);
         grant_q.push_back(mst[k]);
         @(negedge clk);
         check_grant("rmid_issue");
         next_cycle();
      end
      clear_reqs();
      tx_bus.ardy = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h900, 32'h0);
      @(negedge clk);
      check("rmid_stall_addr", tx_bus.addr, 32'h900);
      next_cycle();
      clear_reqs();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      tx_bus.ardy = 1'b1;
      set_req(1, 1'b0, 1'b1, 32'hA10, 32'h1);
      set_req(2, 1'b0, 1'b1, 32'hA20, 32'h2);
      grant_q.push_back(1);
      @(negedge clk);
      check("rmid_err_clr", 32'(err), 32'h0);
      check_grant("rmid_rr0");
      next_cycle();
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      grant_q.push_back(2);
      @(negedge clk);
      check("rmid_m2_addr", tx_bus.addr, 32'hA20);
      check_grant("rmid_m2");
      next_cycle();
      clear_reqs();
      tx_bus.drdy = 1'b1;
      tx_bus.drd  = 32'hC0DE;
      @(negedge clk);
      check_rsp("rmid_empty");
      next_cycle();
      tx_bus.drdy = 1'b0;
      @(negedge clk);
      check("rmid_err_set", 32'(err), 32'h1);
      check("rmid_q_left", 32'(grant_q.size() + rsp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mi_rr_arbiter.md
Name: mi_rr_arbiter

Overview:
- Round-robin arbiter that shares one MI slave bus between MASTERS MI requesters.
- Example requesters: the PCIe MTC plus a local management master.
- Read requests are non-posted. For each accepted read, the block records the issuing master's index in an ordered ID FIFO.
- Returning read data (DRDY) is routed back to the master at the FIFO head.
- The block sits between the MTC MI output and the MI address-space splitter/slave interconnect.

Parameters:
- MASTERS, 2, number of requesting MI masters (≥1).
- DATA_WIDTH, 32, MI data width.
- ADDR_WIDTH, 32, MI address width.
- RD_OUTSTANDING, 16, depth of the ID FIFO (max in-flight reads, power of 2).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- RX_DWR  in  MASTERS*DATA_WIDTH  per-master write data (master i at bits [i*DATA_WIDTH +: DATA_WIDTH])
- RX_ADDR  in  MASTERS*ADDR_WIDTH  per-master address
- RX_BE  in  MASTERS*DATA_WIDTH/8  per-master byte enables
- RX_RD  in  MASTERS  per-master read request
- RX_WR  in  MASTERS  per-master write request
- RX_ARDY  out  MASTERS  per-master request accepted
- RX_DRD  out  MASTERS*DATA_WIDTH  per-master read data
- RX_DRDY  out  MASTERS  per-master read data valid
- TX_DWR / TX_ADDR / TX_BE / TX_RD / TX_WR  out  DATA_WIDTH / ADDR_WIDTH / DATA_WIDTH/8 / 1 / 1  slave-side request
- TX_ARDY  in  1  slave accepts request
- TX_DRD  in  DATA_WIDTH  slave read data
- TX_DRDY  in  1  slave read data valid
- ERR_UNEXP_DRDY  out  1  sticky flag: DRDY arrived with the ID FIFO empty

Behaviour:
- Interface decision: one clock, CLK. RESET is synchronous and active-high.
- Reset state:
  - rr pointer = 0; lock = 0; ID FIFO empty; ERR_UNEXP_DRDY = 0.
  - All outputs are combinationally 0 while no master is selected.
  - Reset mid-transaction drops all in-flight read IDs; later DRDYs set ERR_UNEXP_DRDY.
- Request valid for master i: RX_RD[i] | RX_WR[i]. RD and WR together from one master is illegal (checked by assertion).
- Eligibility: master i is eligible when it requests and (RX_WR[i] or FIFO not full).
- Selection, combinational:
  - If lock = 1, sel = lock_idx.
  - Otherwise sel = first eligible master scanning from the rr pointer upward, with wrap-around.
- Slave-side mux: TX_* = RX_*[sel] when a selection exists; otherwise TX_RD = TX_WR = 0.
- Acceptance: RX_ARDY[sel] = TX_ARDY when a selection exists; all other RX_ARDY bits = 0. Request path latency is 0 cycles.
- Lock register:
  - Set when the selected request is presented and TX_ARDY = 0; lock_idx = sel, lock = 1.
  - Cleared on acceptance.
  - This holds MI request stability: a master's pending request is never preempted.
- On acceptance:
  - rr pointer := (sel + 1) mod MASTERS.
  - If the accepted request is a read, push sel into the ID FIFO.
- FIFO full:
  - Reads are not eligible. A locked read stays presented; the lock only forms after FIFO space was checked.
  - A push coincident with a pop while full is NOT allowed; full blocks the push regardless of a same-cycle pop.
- Response path:
  - On TX_DRDY with the FIFO non-empty: RX_DRDY[head] = 1, RX_DRD[head] = TX_DRD, same cycle. Pop the FIFO.
  - On TX_DRDY with the FIFO empty: nothing is routed, and ERR_UNEXP_DRDY := 1 (sticky until RESET).
  - RX_DRD for non-selected masters is 0.
- Simultaneous push and pop (FIFO not full): both occur; the count is unchanged.
- Throughput: one request per cycle. Back-to-back grants to different masters carry no bubble.

Decomposition:
- Shared package mi_arb_pkg holds:
  - the log2 function;
  - the ID width constant (log2(MASTERS), min 1);
  - the MI request struct typedef (dwr, addr, be, rd, wr).
- One sub-module: mi_arb_id_fifo, a synchronous FIFO of IDs (depth RD_OUTSTANDING, first-word-fall-through, full/empty flags).

Test Plan:
- Round-robin fairness: MASTERS = 3, all masters issue continuous writes, TX_ARDY = 1 → grant order 0,1,2,0,1,2 with no idle cycles; 300 writes give 100 per master.
- Lock under backpressure: master 1 reads address 0x40, TX_ARDY held low for 5 cycles while master 0 requests → TX_ADDR stays 0x40 for all 5 cycles; master 1 is accepted on cycle 6, master 0 on cycle 7.
- Out-of-order latency, in-order return:
  - Stimulus: masters 0,1,0 read addresses A, B, C; the slave returns D1, D2, D3 after 4, 9 and 10 cycles.
  - Required: RX_DRDY pulses go to 0, 1, 0 with the matching data.
- FIFO full: RD_OUTSTANDING = 4, 4 reads in flight, master 0 reads and master 1 writes → the write proceeds; the read is blocked until the first DRDY, then accepted the following cycle.
- Unexpected DRDY: TX_DRDY = 1 with nothing outstanding → no RX_DRDY bit set; ERR_UNEXP_DRDY rises the next cycle and stays 1 until RESET.
- Reset mid-operation: RESET with 3 reads outstanding and a lock active → next cycle shows FIFO empty, lock 0 and rr pointer 0; a new request from master 2 is granted immediately.
